bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Multi-digit loadable BCD down-counter and timer. It is the down-counting counterpart of the team's decade up-counter chain.
- Loads a BCD preset, decrements once per `ce` tick, and flags expiry with a one-cycle `DONE` pulse.
- Used as the countdown and timeout stage in front-panel and display labs, driven by the same prescaled `ce` strobes as the up-counters.

Parameters:
- DIGITS, 2, number of BCD decades (1..8); Q width = 4*DIGITS.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- R  input  1  synchronous active-high reset.
- ce  input  1  count enable (tick strobe); one decrement per cycle with ce=1 while running.
- LD  input  1  load strobe; captures D and starts the countdown.
- D  input  4*DIGITS  BCD preset; digit i = D[4i+3:4i].
- Q  output  4*DIGITS  current BCD count (registered).
- TC  output  1  combinational; 1 when Q == 0 (all digits zero).
- BUSY  output  1  registered; 1 while in state RUN.
- DONE  output  1  registered; one-cycle pulse on expiry.

Behaviour:
- Clock and reset: single clock `clk`; reset `R` is synchronous and active-high.
- Reset values: Q=0, BUSY=0, DONE=0, state=IDLE; internal reload register=0. TC=1 follows from Q=0.
- Priority per edge: R > LD > ce.
- States:
  - IDLE: Q holds; ce ignored.
  - RUN: counting.
- Transitions:
  - LD=1 (any state), loaded value nonzero → next edge: Q=D', state RUN, BUSY=1, DONE=0.
  - LD=1, loaded value all-zero → Q=0, state IDLE, BUSY=0, no DONE pulse.
  - RUN, ce=1, Q>1 → Q=Q-1 in BCD.
  - RUN, ce=1, Q==1 → Q=0, DONE=1 for exactly that one cycle, state IDLE, BUSY=0 (same edge).
  - RUN, ce=0 → Q holds (pause); no state change.
- Load sanitising (D'): any input digit >9 is loaded as 9. The other digits load unchanged.
- BCD decrement:
  - Digit 0 always steps when decrementing.
  - Digit i>0 steps only when digits 0..i-1 are all 0 (borrow chain).
  - A stepping digit goes 0→9, otherwise d→d-1.
  - Q never wraps below 0 because RUN exits at 1→0.
- LD during RUN restarts from the new D' with no DONE. LD coinciding with the 1→0 decrement: LD wins, no DONE.
- R mid-count: returns to the reset values on the next edge, and any DONE pulse is cancelled.
- DONE is never asserted for two consecutive cycles; DONE=0 in every cycle in which BUSY is entered.
- Latency: LD→Q valid, 1 cycle. ce→Q update, 1 cycle. Final tick→DONE, 1 cycle, coincident with Q=0.

Optional Feature:
- Macro: BCD_AUTO_RELOAD_EN.
- Defined:
  - The reload register captures D' on every LD.
  - On the RUN ce tick with Q==1: DONE pulses, Q is loaded with the reload value instead of 0, and the state stays RUN (BUSY stays 1). Periodic operation, period = reload value ticks.
  - An all-zero load still goes to IDLE.
  - R clears the reload register.
- Not defined:
  - No reload register is synthesised.
  - Expiry goes to IDLE with Q=0 as described above.

Test Plan:
1. DIGITS=2, R for 2 cycles, then idle with ce=1 → Q=00, TC=1, BUSY=0, DONE never 1.
2. LD with D=8'h03, then ce=1 continuously → Q: 03, 02, 01, 00. DONE=1 only in the cycle Q=00, and BUSY falls on that same edge. Further ce leaves Q=00.
3. LD D=8'h20, ce=1 → Q 20→19→18, confirming the borrow chain. LD D=8'h1F → Q=19 (sanitised).
4. LD D=8'h05, ce asserted every 3rd cycle → Q decrements only on ce cycles. DONE appears 1 cycle after the 5th ce.
5. LD D=8'h02, one ce tick (Q=01), then assert R on the next ce → Q=00, BUSY=0, no DONE. Separately, LD D=8'h09 in the same cycle as the Q 01→00 tick → Q=09, BUSY=1, no DONE.
6. With BCD_AUTO_RELOAD_EN defined: LD D=8'h02, ce=1 continuously → Q 02,01,02,01,… with DONE pulsing every 2 cycles and BUSY held at 1. Without the macro, the same stimulus ends at Q=00 with BUSY=0.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// ----------------------------------------------------------------------------
// bcd_countdown_timer
//
// Multi-digit loadable BCD down-counter / timer. A load captures a sanitised
// BCD preset and starts the countdown. Each ce tick while running decrements
// the count by one in BCD. The final 1 -> 0 tick raises a single-cycle done
// pulse and returns the block to idle.
//
// Optional feature (macro BCD_AUTO_RELOAD_EN):
//   When the macro is defined, the block keeps a reload register that captures
//   the sanitised preset on every load. On expiry the count is reloaded from
//   this register, done still pulses, and the block stays running. This gives
//   periodic operation. When the macro is undefined, no reload register exists.
//
// Parameters:
//   DIGITS   number of BCD decades (1..8); count width is 4*DIGITS
//
// Ports:
//   clk_i    system clock; all state changes on posedge
//   r_i      synchronous active-high reset
//   ce_i     count enable tick; one decrement per cycle while running
//   ld_i     load strobe; captures d_i and starts the countdown
//   d_i      BCD preset; digit i = d_i[4i+3:4i]; digits > 9 load as 9
//   q_o      current BCD count (registered)
//   tc_o     combinational; 1 when q_o is all zero
//   busy_o   registered; 1 while running
//   done_o   registered; one-cycle pulse on expiry
// ----------------------------------------------------------------------------
module bcd_countdown_timer #(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  clk_i,
   input  logic                  r_i,
   input  logic                  ce_i,
   input  logic                  ld_i,
   input  logic [4*DIGITS-1:0]   d_i,
   output logic [4*DIGITS-1:0]   q_o,
   output logic                  tc_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned W = 4 * DIGITS;
   localparam logic [W-1:0] QOne = W'(1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e         state_q;
   logic [W-1:0]   q_q;
   logic           busy_q;
   logic           done_q;
   logic [W-1:0]   ld_val;
   logic [W-1:0]   dec_val;

`ifdef BCD_AUTO_RELOAD_EN
   logic [W-1:0]   reload_q;
`endif

   // Clamp each preset digit to 9 so the count always holds legal BCD.
   always_comb begin
      ld_val = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (d_i[4*i +: 4] > 4'd9) begin
            ld_val[4*i +: 4] = 4'd9;
         end else begin
            ld_val[4*i +: 4] = d_i[4*i +: 4];
         end
      end
   end

   // BCD decrement with a borrow chain. A digit steps only when every lower
   // digit is zero. A zero digit that steps wraps to 9 and passes the borrow
   // on to the next digit.
   always_comb begin
      logic borrow;
      dec_val = q_q;
      borrow  = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (borrow) begin
            if (q_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   // Edge priority is reset, then load, then ce.
   always_ff @(posedge clk_i) begin
      if (r_i) begin
         state_q  <= StIdle;
         q_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (ld_i) begin
            q_q <= ld_val;
`ifdef BCD_AUTO_RELOAD_EN
            reload_q <= ld_val;
`endif
            // An all-zero preset has nothing to count, so the block stays idle.
            if (ld_val != '0) begin
               state_q <= StRun;
               busy_q  <= 1'b1;
            end else begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         end else if (state_q == StRun && ce_i) begin
            if (q_q == QOne) begin
               done_q <= 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
               // The reload value is nonzero here, because entering the run
               // state requires a nonzero load.
               q_q <= reload_q;
`else
               q_q     <= '0;
               state_q <= StIdle;
               busy_q  <= 1'b0;
`endif
            end else begin
               q_q <= dec_val;
            end
         end
      end
   end

   assign q_o    = q_q;
   assign tc_o   = (q_q == '0);
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_bcd_countdown_timer
//
// Directed self-checking bench for bcd_countdown_timer with DIGITS=2. It
// exercises reset, plain countdown, the borrow chain, preset sanitising,
// sparse ce, reset and load interactions near expiry, and expiry behaviour.
// Expiry expectations depend on whether BCD_AUTO_RELOAD_EN is defined.
// ----------------------------------------------------------------------------
module tb_bcd_countdown_timer;

   localparam int unsigned DIGITS = 2;

   logic                clk;
   logic                r;
   logic                ce;
   logic                ld;
   logic [4*DIGITS-1:0] d;
   logic [4*DIGITS-1:0] q;
   logic                tc;
   logic                busy;
   logic                done;

   int unsigned n_total  = 0;
   int unsigned n_passed = 0;
   int unsigned n_failed = 0;

   bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
      .clk_i  (clk),
      .r_i    (r),
      .ce_i   (ce),
      .ld_i   (ld),
      .d_i    (d),
      .q_o    (q),
      .tc_o   (tc),
      .busy_o (busy),
      .done_o (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_passed++;
      else begin
         n_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check every output at once; tc is implied by the expected q.
   task automatic chk_all(input string tag, input logic [7:0] eq, input logic eb,
                          input logic ed);
      chk({tag, ".q"},    32'(q),    32'(eq));
      chk({tag, ".tc"},   32'(tc),   32'(eq == 8'h00));
      chk({tag, ".busy"}, 32'(busy), 32'(eb));
      chk({tag, ".done"}, 32'(done), 32'(ed));
   endtask

   initial begin
      // Reset held for 2 cycles
      r = 1'b1; ce = 1'b0; ld = 1'b0; d = '0;
      tick(); tick();
      chk_all("rst", 8'h00, 1'b0, 1'b0);

      // Idle with ce=1: nothing moves
      r = 1'b0; ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("idle_ce", 8'h00, 1'b0, 1'b0);
      end

      // Countdown from 03
      ld = 1'b1; d = 8'h03;
      tick(); chk_all("ld03", 8'h03, 1'b1, 1'b0);
      ld = 1'b0;
      tick(); chk_all("c02", 8'h02, 1'b1, 1'b0);
      tick(); chk_all("c01", 8'h01, 1'b1, 1'b0);
      tick(); chk_all("c00", 8'h00, 1'b0, 1'b1);
      tick(); chk_all("c00_hold", 8'h00, 1'b0, 1'b0);

      // Borrow chain; ce asserted with ld, so ld wins
      ld = 1'b1; d = 8'h20;
      tick(); chk_all("ld20", 8'h20, 1'b1, 1'b0);
      ld = 1'b0;
      tick(); chk_all("b19", 8'h19, 1'b1, 1'b0);
      tick(); chk_all("b18", 8'h18, 1'b1, 1'b0);
      // Sanitising; reload during run without done
      ld = 1'b1; d = 8'h1F;
      tick(); chk_all("ld1F", 8'h19, 1'b1, 1'b0);
      d = 8'hFA;
      tick(); chk_all("ldFA", 8'h99, 1'b1, 1'b0);
      d = 8'hB0;
      tick(); chk_all("ldB0", 8'h90, 1'b1, 1'b0);
      ld = 1'b0;
      tick(); chk_all("b89", 8'h89, 1'b1, 1'b0);

      // Sparse ce: every 3rd cycle
      ce = 1'b0; ld = 1'b1; d = 8'h05;
      tick(); chk_all("ld05", 8'h05, 1'b1, 1'b0);
      ld = 1'b0;
      for (int k = 4; k >= 0; k--) begin
         ce = 1'b0;
         tick(); chk_all("sp_hold", 8'(k + 1), 1'b1, 1'b0);
         tick(); chk_all("sp_hold", 8'(k + 1), 1'b1, 1'b0);
         ce = 1'b1;
         tick(); chk_all("sp_dec", 8'(k), (k != 0), (k == 0));
      end
      ce = 1'b0;
      tick(); chk_all("sp_after", 8'h00, 1'b0, 1'b0);

      // Reset on the final tick cancels done
      ld = 1'b1; d = 8'h02;
      tick(); chk_all("r_ld02", 8'h02, 1'b1, 1'b0);
      ld = 1'b0; ce = 1'b1;
      tick(); chk_all("r_c01", 8'h01, 1'b1, 1'b0);
      r = 1'b1;
      tick(); chk_all("r_mid", 8'h00, 1'b0, 1'b0);
      r = 1'b0; ce = 1'b0;

      // Load coinciding with the final tick: load wins, no done
      ld = 1'b1; d = 8'h02;
      tick(); chk_all("l_ld02", 8'h02, 1'b1, 1'b0);
      ld = 1'b0; ce = 1'b1;
      tick(); chk_all("l_c01", 8'h01, 1'b1, 1'b0);
      ld = 1'b1; d = 8'h09;
      tick(); chk_all("l_ld09", 8'h09, 1'b1, 1'b0);
      ld = 1'b0;
      tick(); chk_all("l_c08", 8'h08, 1'b1, 1'b0);
      // Zero load goes idle
      ld = 1'b1; d = 8'h00;
      tick(); chk_all("ld00", 8'h00, 1'b0, 1'b0);
      ld = 1'b0;
      tick(); chk_all("ld00_hold", 8'h00, 1'b0, 1'b0);

      // Expiry with continuous ce from 02
      ld = 1'b1; d = 8'h02;
      tick(); chk_all("e_ld02", 8'h02, 1'b1, 1'b0);
      ld = 1'b0;
      tick(); chk_all("e_c01", 8'h01, 1'b1, 1'b0);
`ifdef BCD_AUTO_RELOAD_EN
      tick(); chk_all("e_rl02", 8'h02, 1'b1, 1'b1);
      tick(); chk_all("e_rl01", 8'h01, 1'b1, 1'b0);
      tick(); chk_all("e_rl02b", 8'h02, 1'b1, 1'b1);
      tick(); chk_all("e_rl01b", 8'h01, 1'b1, 1'b0);
`else
      tick(); chk_all("e_c00", 8'h00, 1'b0, 1'b1);
      tick(); chk_all("e_hold", 8'h00, 1'b0, 1'b0);
      tick(); chk_all("e_hold2", 8'h00, 1'b0, 1'b0);
`endif
      // Reset from run
      r = 1'b1;
      tick(); chk_all("e_rst", 8'h00, 1'b0, 1'b0);
      r = 1'b0;
      tick(); chk_all("e_idle", 8'h00, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
